// File: rtl/fu_pkg.sv
// Shared definitions for the FU result path.
// Contents:
//   - operand-mode encodings for the precision-scalable FU
//   - the number of sub-word lanes per mode
//   - the accumulator FSM state type
package fu_pkg;

    localparam logic [1:0] MODE_8X8 = 2'b00;
    localparam logic [1:0] MODE_4X4 = 2'b01;
    localparam logic [1:0] MODE_2X2 = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;

    // Lanes carried by one packed product word in the given mode.
    // The illegal mode carries no lanes.
    function automatic logic [2:0] lane_count(input logic [1:0] mode);
        case (mode)
            MODE_8X8: lane_count = 3'd1;
            MODE_4X4: lane_count = 3'd2;
            MODE_2X2: lane_count = 3'd4;
            default:  lane_count = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/fu_lane_unpack.sv
// Splits a packed 16-bit FU product word into four unsigned lane values.
// Each value is zero-extended to ACC_W bits.
// Lanes that do not exist in the current mode read as zero.
// Ports:
//   in_p   in  16        packed product word
//   mode   in  2         operand mode (fu_pkg MODE_*)
//   lanes  out 4*ACC_W   lane k at [k*ACC_W +: ACC_W]
module fu_lane_unpack
    import fu_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic [15:0]          in_p,
    input  logic [1:0]           mode,
    output logic [4*ACC_W-1:0]   lanes
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            // The truncating casts take the nibble or byte belonging to this lane.
            // They avoid part-selects past bit 15 for the upper lanes.
            logic [3:0]       nib;
            logic [7:0]       byt;
            logic [ACC_W-1:0] lane;

            assign nib = 4'(in_p >> (4 * gi));
            assign byt = 8'(in_p >> (8 * gi));

            always_comb begin
                lane = '0;
                case (mode)
                    MODE_8X8: if (gi == 0) lane = ACC_W'(in_p);
                    MODE_4X4: if (gi < 2)  lane = ACC_W'(byt);
                    MODE_2X2:              lane = ACC_W'(nib);
                    default:               lane = '0;
                endcase
            end

            assign lanes[gi*ACC_W +: ACC_W] = lane;
        end
    endgenerate

endmodule

// File: rtl/fu_result_accum.sv
// Per-lane accumulator for the packed product words of the precision-scalable FU.
// A start pulse in IDLE latches the mode and the tile length.
// The block then sums cfg_len product words per lane.
// The sums are presented on a valid/ready output until the output handshake completes.
// Build option: define FU_ACC_SAT_EN for saturating lanes.
//   With FU_ACC_SAT_EN, each lane saturates at all-ones and sets a sticky flag on sat_flag.
//   Otherwise the lanes wrap and sat_flag does not exist.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a tile (honoured only in IDLE)
//   cfg_mode, cfg_len   mode and product count, latched on start
//   in_valid/in_ready   product word input handshake; in_p is the data
//   out_valid/out_ready result handshake; out_acc carries 4 lanes
//   busy                not IDLE
//   sat_flag            per-lane saturation flags (FU_ACC_SAT_EN only)
//   err_mode            sticky flag for a start with the illegal mode
module fu_result_accum
    import fu_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           cfg_mode,
    input  logic [CNT_W-1:0]     cfg_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*ACC_W-1:0]   out_acc,
    output logic                 busy,
`ifdef FU_ACC_SAT_EN
    output logic [3:0]           sat_flag,
`endif
    output logic                 err_mode
);

    fsm_state_t         state_reg, state_next;
    logic [1:0]         mode_reg;
    logic [CNT_W-1:0]   len_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               in_ready_reg, in_ready_next;
    logic               out_valid_reg, out_valid_next;
    logic               err_mode_reg;
    logic [4*ACC_W-1:0] lane_val;

    logic start_ok;
    logic start_bad;
    logic in_hs;
    logic out_hs;
    logic last_word;

    assign start_ok  = (state_reg == ST_IDLE) && start && (cfg_mode != MODE_ILL);
    assign start_bad = (state_reg == ST_IDLE) && start && (cfg_mode == MODE_ILL);
    assign in_hs     = in_valid && in_ready_reg;
    assign out_hs    = out_valid_reg && out_ready;
    assign last_word = (count_reg == (len_reg - CNT_W'(1)));

    fu_lane_unpack #(.ACC_W(ACC_W)) u_unpack (
        .in_p  (in_p),
        .mode  (mode_reg),
        .lanes (lane_val)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_ok)
                          state_next = (cfg_len == '0) ? ST_DRAIN : ST_ACCUM;
            ST_ACCUM: if (in_hs && last_word) state_next = ST_DRAIN;
            ST_DRAIN: if (out_hs) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The handshake outputs are registered and derive from the upcoming state.
    // This gives a one-cycle latency from the last input word to out_valid.
    // It also drops in_ready in the cycle right after the final word.
    always_comb begin
        in_ready_next  = (state_next == ST_ACCUM);
        out_valid_next = (state_next == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            mode_reg      <= MODE_8X8;
            len_reg       <= '0;
            count_reg     <= '0;
            err_mode_reg  <= 1'b0;
        end else begin
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
            if (start_ok) begin
                mode_reg     <= cfg_mode;
                len_reg      <= cfg_len;
                count_reg    <= '0;
                err_mode_reg <= 1'b0;
            end else begin
                if (in_hs)     count_reg    <= count_reg + CNT_W'(1);
                if (start_bad) err_mode_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_acc
            logic             lane_on;
            logic [ACC_W-1:0] acc_reg;
            logic [ACC_W-1:0] add_val;

            assign lane_on = (3'(gi) < lane_count(mode_reg));
            assign add_val = lane_val[gi*ACC_W +: ACC_W];

`ifdef FU_ACC_SAT_EN
            // One extra bit catches the carry-out that triggers saturation.
            logic [ACC_W:0] sum;
            logic           sat_reg;

            assign sum = {1'b0, acc_reg} + {1'b0, add_val};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                    sat_reg <= 1'b0;
                end else if (start_ok) begin
                    acc_reg <= '0;
                    sat_reg <= 1'b0;
                end else if (in_hs && lane_on) begin
                    if (sum[ACC_W]) begin
                        acc_reg <= '1;
                        sat_reg <= 1'b1;
                    end else begin
                        acc_reg <= sum[ACC_W-1:0];
                    end
                end
            end

            assign sat_flag[gi] = sat_reg;
`else
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                acc_reg <= '0;
                else if (start_ok)         acc_reg <= '0;
                else if (in_hs && lane_on) acc_reg <= acc_reg + add_val;
            end
`endif
            // Inactive lanes are cleared on start and never add.
            // They therefore read as zero without an output mask.
            assign out_acc[gi*ACC_W +: ACC_W] = acc_reg;
        end
    endgenerate

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign err_mode  = err_mode_reg;

endmodule

// File: tb/tb_fu_result_accum.sv
// Directed bench for fu_result_accum.
// Two instances share the same stimulus: a 32-bit-lane one and a 16-bit-lane one.
// The 16-bit instance covers the overflow case.
// Build option: define FU_ACC_SAT_EN to select saturating lanes.
module tb_fu_result_accum;
    import fu_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   cfg_mode;
    logic [15:0]  cfg_len;
    logic         in_valid;
    logic [15:0]  in_p;
    logic         out_ready;
    logic         in_ready, in_ready16;
    logic         out_valid, out_valid16;
    logic [127:0] out_acc;
    logic [63:0]  out_acc16;
    logic         busy, busy16;
    logic         err_mode, err_mode16;
`ifdef FU_ACC_SAT_EN
    logic [3:0]   sat_flag, sat_flag16;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fu_result_accum #(.ACC_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .busy(busy),
`ifdef FU_ACC_SAT_EN
        .sat_flag(sat_flag),
`endif
        .err_mode(err_mode)
    );

    fu_result_accum #(.ACC_W(16), .CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready16), .in_p(in_p),
        .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16),
        .busy(busy16),
`ifdef FU_ACC_SAT_EN
        .sat_flag(sat_flag16),
`endif
        .err_mode(err_mode16)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [15:0] l);
        start    = 1'b1;
        cfg_mode = m;
        cfg_len  = l;
        step();
        start    = 1'b0;
        // Later config changes must be ignored.
        cfg_mode = 2'b00;
        cfg_len  = 16'hFFFF;
    endtask

    task automatic feed(input logic [15:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_p     = w;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        in_p     = 16'h0000;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("out_valid_timeout", 128'(out_valid), 128'd1);
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    logic [127:0] exp_acc;

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_mode = 2'b00; cfg_len = '0;
        in_valid = 1'b0; in_p = '0; out_ready = 1'b0;
        #12;
        check("rst_busy",  128'(busy),      128'd0);
        check("rst_rdy",   128'(in_ready),  128'd0);
        check("rst_ov",    128'(out_valid), 128'd0);
        check("rst_err",   128'(err_mode),  128'd0);
        check("rst_acc",   out_acc,         128'd0);
        step();
        rst_n = 1'b1;
        step();

        // 4x4, len=2, 0x0A05 twice: lane0 = 5+5, lane1 = 10+10
        do_start(MODE_4X4, 16'd2);
        check("t1_busy", 128'(busy),     128'd1);
        check("t1_rdy",  128'(in_ready), 128'd1);
        feed(16'h0A05);
        check("t1_ov_early", 128'(out_valid), 128'd0);
        feed(16'h0A05);
        check("t1_ov_lat", 128'(out_valid), 128'd1);
        check("t1_rdy_drop", 128'(in_ready), 128'd0);
        exp_acc = {32'd0, 32'd0, 32'd20, 32'd10};
        check("t1_acc", out_acc, exp_acc);
        // Stall for 5 cycles; a start with the illegal mode during DRAIN must be ignored.
        out_ready = 1'b0;
        start = 1'b1; cfg_mode = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall%0d_ov", i),  128'(out_valid), 128'd1);
            check($sformatf("stall%0d_acc", i), out_acc,         exp_acc);
            check($sformatf("stall%0d_rdy", i), 128'(in_ready),  128'd0);
        end
        start = 1'b0; cfg_mode = 2'b00;
        check("stall_err", 128'(err_mode), 128'd0);
        take_out();
        check("t1_ov_done", 128'(out_valid), 128'd0);
        check("t1_idle",    128'(busy),      128'd0);
        check("t1_hold",    out_acc,         exp_acc);

        // 2x2, len=3, 0xF1E2 x3: nibbles 2,E,1,F, each times 3
        do_start(MODE_2X2, 16'd3);
        for (int i = 0; i < 3; i++) feed(16'hF1E2);
        wait_out();
        check("t2_acc", out_acc, {32'd45, 32'd3, 32'd42, 32'd6});
        take_out();

        // 8x8, len=4, 0xFFFF with a one-cycle gap between words
        do_start(MODE_8X8, 16'd4);
        for (int i = 0; i < 4; i++) begin
            feed(16'hFFFF);
            if (i < 3) step();
        end
        check("t3_ov_lat", 128'(out_valid), 128'd1);
        check("t3_acc", out_acc, {96'd0, 32'h0003_FFFC});
        take_out();

        // 8x8, len=2, 0xFFFF: the 16-bit lanes overflow
        do_start(MODE_8X8, 16'd2);
        feed(16'hFFFF);
        feed(16'hFFFF);
        wait_out();
        check("t4_acc32", out_acc, {96'd0, 32'h0001_FFFE});
`ifdef FU_ACC_SAT_EN
        check("t4_acc16_sat", 128'(out_acc16), {64'd0, 48'd0, 16'hFFFF});
        check("t4_flag16",    128'(sat_flag16), 128'd1);
        check("t4_flag32",    128'(sat_flag),   128'd0);
`else
        check("t4_acc16_wrap", 128'(out_acc16), {64'd0, 48'd0, 16'hFFFE});
`endif
        take_out();

        // Illegal mode, then a legal start with len=0
        do_start(MODE_ILL, 16'd3);
        check("t5_err",  128'(err_mode), 128'd1);
        check("t5_busy", 128'(busy),     128'd0);
        check("t5_rdy",  128'(in_ready), 128'd0);
        do_start(MODE_8X8, 16'd0);
        check("t6_err_clr", 128'(err_mode),  128'd0);
        check("t6_ov",      128'(out_valid), 128'd1);
        check("t6_acc0",    out_acc,         128'd0);
`ifdef FU_ACC_SAT_EN
        check("t6_flag_clr", 128'(sat_flag16), 128'd0);
`endif
        in_valid = 1'b1; in_p = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t6_rdy%0d", i), 128'(in_ready), 128'd0);
            step();
        end
        check("t6_acc_hold", out_acc, 128'd0);
        in_valid = 1'b0; in_p = 16'h0;
        take_out();
        check("t6_idle", 128'(busy), 128'd0);

        // Asynchronous reset part-way through an ACCUM tile
        do_start(MODE_4X4, 16'd4);
        feed(16'h0303);
        check("t7_busy", 128'(busy), 128'd1);
        #3 rst_n = 1'b0;
        #1;
        check("t7_busy_rst", 128'(busy),      128'd0);
        check("t7_rdy_rst",  128'(in_ready),  128'd0);
        check("t7_ov_rst",   128'(out_valid), 128'd0);
        check("t7_acc_rst",  out_acc,         128'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t7_stay_idle", 128'(out_valid), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
